// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types and encodings for the core-side bus arbiter and its
// reusable helpers.
package cbus_arbiter_pkg;

   typedef logic [2:0] cbus_size_t;
   localparam cbus_size_t CBUS_SIZE_1 = 3'd0;
   localparam cbus_size_t CBUS_SIZE_2 = 3'd1;
   localparam cbus_size_t CBUS_SIZE_4 = 3'd2;
   localparam cbus_size_t CBUS_SIZE_8 = 3'd3;

   // len is beats minus one
   typedef logic [3:0] cbus_len_t;
   localparam cbus_len_t CBUS_LEN_1  = 4'd0;
   localparam cbus_len_t CBUS_LEN_2  = 4'd1;
   localparam cbus_len_t CBUS_LEN_4  = 4'd3;
   localparam cbus_len_t CBUS_LEN_8  = 4'd7;
   localparam cbus_len_t CBUS_LEN_16 = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      cbus_size_t  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } cbus_arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Upstream request/response array and the single downstream CBus port seen by
// the arbiter.
interface cbus_arbiter_if
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2
);
   cbus_req_t  ireqs  [NUM_MASTERS];
   cbus_resp_t iresps [NUM_MASTERS];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   // slave: the arbiter, which serves the upstream masters
   modport slave  (input ireqs, output iresps, output oreq, input oresp);
   modport master (output ireqs, input iresps, input oreq, output oresp);
endinterface

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin select: first valid requester after last_grant,
// wrapping modulo N.
module rr_picker
   import cbus_arbiter_pkg::*;
#(
   parameter  int N = 2,
   localparam int W = idx_width(N)
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] idx,
   output logic         found
);
   localparam int unsigned NU = N;

   logic [W-1:0] cidx;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cidx  = '0;
      // Offsets 1..N visit every master once; the previous winner comes last.
      for (int unsigned k = 1; k <= NU; k++) begin
         cidx = W'((32'(last_grant) + k) % NU);
         if (!found && valid[cidx]) begin
            idx   = cidx;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin N-to-1 CBus arbiter: one master owns the downstream port from
// grant until its final response beat, with an idle bubble between owners.
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
   input  logic             clk,
   input  logic             reset,
   cbus_arbiter_if.slave    bus,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);
   localparam int unsigned NM = NUM_MASTERS;

   cbus_arb_state_t  state_q, state_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [IDX_W-1:0] pick;
   logic [NM-1:0]    valid;
   logic             found;

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_valid
      assign valid[g] = bus.ireqs[g].valid;
   end

   rr_picker #(.N(NUM_MASTERS)) u_picker (
      .valid      (valid),
      .last_grant (last_grant_q),
      .idx        (pick),
      .found      (found)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         last_grant_q <= IDX_W'(NM - 1);
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      bus.oreq     = '0;
      bus.iresps   = '{default: '0};
      unique case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            bus.oreq          = bus.ireqs[sel_q];
            bus.iresps[sel_q] = bus.oresp;
            if (bus.oresp.ready && bus.oresp.last) begin
               last_grant_d = sel_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == BUSY);
   assign grant_idx = sel_q;

   // Owner dropping valid mid-transaction is a master bug; forwarding continues regardless.
   a_owner_holds_valid: assert property (
      @(posedge clk) disable iff (reset) (state_q == BUSY) |-> bus.ireqs[sel_q].valid
   );
endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed table and corner sequences, then random
// traffic against a transaction-level ownership model.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam int NM = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       busy;
   logic [0:0] grant_idx;

   int n_tests = 0;
   int n_fail  = 0;

   cbus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   cbus_arbiter #(.NUM_MASTERS(NM)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   cbus_req_t req_m [NM];

   typedef struct {
      logic [1:0] v;
      logic       rdy;
      logic       lst;
      logic       exp_busy;
      logic       exp_gidx;
      logic       exp_ov;
      logic [1:0] exp_r;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic rdy, input logic lst, input logic [31:0] d);
      for (int m = 0; m < NM; m++) begin
         bus.ireqs[m]       = req_m[m];
         bus.ireqs[m].valid = v[m];
      end
      bus.oresp.ready = rdy;
      bus.oresp.last  = lst;
      bus.oresp.data  = d;
   endtask

   task automatic cyc(input logic [1:0] v, input logic rdy, input logic lst, input logic [31:0] d);
      @(negedge clk);
      drive(v, rdy, lst, d);
      #1;
   endtask

   task automatic do_reset(input bit check);
      @(negedge clk);
      reset = 1'b1;
      drive(2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      if (check) begin
         chk("reset busy", 128'(busy), 128'(1'b0));
         chk("reset grant_idx", 128'(grant_idx), 128'(1'b0));
         chk("reset oreq", 128'(bus.oreq), 128'(0));
         chk("reset iresps0", 128'(bus.iresps[0]), 128'(0));
         chk("reset iresps1", 128'(bus.iresps[1]), 128'(0));
      end
      reset = 1'b0;
      drive(2'b00, 1'b0, 1'b0, 32'h0);
   endtask

   function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] a, input cbus_len_t l);
      cbus_req_t r;
      r          = '0;
      r.is_write = wr;
      r.size     = CBUS_SIZE_4;
      r.addr     = a;
      r.strobe   = 4'hF;
      r.data     = a ^ 32'h5A5A_0000;
      r.len      = l;
      return r;
   endfunction

   function automatic cbus_req_t rnd_req();
      logic [95:0] rb;
      rb = {$urandom(), $urandom(), $urandom()};
      return rb[76:0];
   endfunction

   vec_t tbl [10];

   // random-phase model state
   int         owner, prev, gidx, beat;
   bit         act [NM];
   cbus_req_t  cur [NM];
   cbus_req_t  drv [NM];
   cbus_resp_t rsp;
   cbus_req_t  exp_oreq;
   cbus_resp_t exp_rsp;

   initial begin
      drive(2'b00, 1'b0, 1'b0, 32'h0);

      // single read after reset
      req_m[0] = mk_req(1'b0, 32'hBFC0_0000, CBUS_LEN_1);
      req_m[1] = mk_req(1'b1, 32'h8000_1000, CBUS_LEN_1);
      do_reset(1'b1);
      cyc(2'b01, 1'b0, 1'b0, 32'h0);
      chk("single first-seen oreq.valid", 128'(bus.oreq.valid), 128'(1'b0));
      chk("single first-seen busy", 128'(busy), 128'(1'b0));
      cyc(2'b01, 1'b1, 1'b1, 32'h3C1D_BFC0);
      chk("single oreq.valid", 128'(bus.oreq.valid), 128'(1'b1));
      chk("single oreq.addr", 128'(bus.oreq.addr), 128'(32'hBFC0_0000));
      chk("single iresps0.data", 128'(bus.iresps[0].data), 128'(32'h3C1D_BFC0));
      chk("single iresps0.ready", 128'(bus.iresps[0].ready), 128'(1'b1));
      chk("single iresps1.ready", 128'(bus.iresps[1].ready), 128'(1'b0));
      chk("single busy", 128'(busy), 128'(1'b1));
      cyc(2'b00, 1'b0, 1'b0, 32'h0);
      chk("single busy after", 128'(busy), 128'(1'b0));

      // contention and back-to-back completion, one row per cycle
      tbl[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      tbl[1] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
      tbl[2] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      tbl[3] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
      tbl[4] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
      tbl[5] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[6] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
      tbl[7] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      tbl[8] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
      tbl[9] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      do_reset(1'b0);
      for (int r = 0; r < 10; r++) begin
         cyc(tbl[r].v, tbl[r].rdy, tbl[r].lst, $urandom());
         chk($sformatf("tbl[%0d] busy", r), 128'(busy), 128'(tbl[r].exp_busy));
         chk($sformatf("tbl[%0d] grant_idx", r), 128'(grant_idx), 128'(tbl[r].exp_gidx));
         chk($sformatf("tbl[%0d] oreq.valid", r), 128'(bus.oreq.valid), 128'(tbl[r].exp_ov));
         chk($sformatf("tbl[%0d] ready", r), 128'({bus.iresps[1].ready, bus.iresps[0].ready}),
             128'(tbl[r].exp_r));
         if (tbl[r].exp_ov)
            chk($sformatf("tbl[%0d] oreq.addr", r), 128'(bus.oreq.addr),
                128'(req_m[int'(tbl[r].exp_gidx)].addr));
      end

      // burst lock: master 1 writes 4 beats, master 0 arrives mid-burst
      req_m[1] = mk_req(1'b1, 32'h8000_2000, CBUS_LEN_4);
      do_reset(1'b0);
      cyc(2'b10, 1'b0, 1'b0, 32'h0);
      chk("burst idle busy", 128'(busy), 128'(1'b0));
      for (int b = 0; b < 4; b++) begin
         cyc((b >= 1) ? 2'b11 : 2'b10, 1'b1, (b == 3), 32'hA0 + b);
         chk($sformatf("burst b%0d iresps0.ready", b), 128'(bus.iresps[0].ready), 128'(1'b0));
         chk($sformatf("burst b%0d iresps1.ready", b), 128'(bus.iresps[1].ready), 128'(1'b1));
         chk($sformatf("burst b%0d iresps1.last", b), 128'(bus.iresps[1].last), 128'(b == 3));
         chk($sformatf("burst b%0d grant_idx", b), 128'(grant_idx), 128'(1'b1));
      end
      cyc(2'b01, 1'b0, 1'b0, 32'h0);
      chk("burst bubble busy", 128'(busy), 128'(1'b0));
      cyc(2'b01, 1'b1, 1'b1, 32'h1234);
      chk("burst then m0 busy", 128'(busy), 128'(1'b1));
      chk("burst then m0 grant", 128'(grant_idx), 128'(1'b0));
      cyc(2'b00, 1'b0, 1'b0, 32'h0);

      // fairness with both masters permanently requesting
      req_m[1] = mk_req(1'b1, 32'h8000_1000, CBUS_LEN_1);
      do_reset(1'b0);
      for (int t = 0; t < 6; t++) begin
         cyc(2'b11, 1'b1, 1'b1, $urandom());
         chk($sformatf("fair t%0d bubble", t), 128'(busy), 128'(1'b0));
         cyc(2'b11, 1'b1, 1'b1, $urandom());
         chk($sformatf("fair t%0d busy", t), 128'(busy), 128'(1'b1));
         chk($sformatf("fair t%0d grant", t), 128'(grant_idx), 128'(t % 2));
      end
      cyc(2'b00, 1'b0, 1'b0, 32'h0);

      // reset during beat 2 of a 4-beat read
      req_m[1] = mk_req(1'b0, 32'h8000_3000, CBUS_LEN_4);
      do_reset(1'b0);
      cyc(2'b11, 1'b0, 1'b0, 32'h0);
      cyc(2'b11, 1'b1, 1'b1, 32'h0);
      chk("rstmid m0 grant", 128'(grant_idx), 128'(1'b0));
      cyc(2'b10, 1'b0, 1'b0, 32'h0);
      cyc(2'b10, 1'b1, 1'b0, 32'h0);
      chk("rstmid beat1 busy", 128'(busy), 128'(1'b1));
      chk("rstmid beat1 grant", 128'(grant_idx), 128'(1'b1));
      @(negedge clk);
      reset = 1'b1;
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rstmid after busy", 128'(busy), 128'(1'b0));
      chk("rstmid after oreq.valid", 128'(bus.oreq.valid), 128'(1'b0));
      chk("rstmid after grant", 128'(grant_idx), 128'(1'b0));
      cyc(2'b11, 1'b0, 1'b0, 32'h0);
      chk("rstmid m0 priority busy", 128'(busy), 128'(1'b1));
      chk("rstmid m0 priority grant", 128'(grant_idx), 128'(1'b0));
      cyc(2'b11, 1'b1, 1'b1, 32'h0);
      cyc(2'b00, 1'b0, 1'b0, 32'h0);

      // random traffic against an ownership model
      do_reset(1'b0);
      owner = -1;
      prev  = NM - 1;
      gidx  = 0;
      beat  = 0;
      for (int m = 0; m < NM; m++) act[m] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int m = 0; m < NM; m++) begin
            if (!act[m] && $urandom_range(0, 2) == 0) begin
               act[m]       = 1'b1;
               cur[m]       = rnd_req();
               cur[m].valid = 1'b1;
               cur[m].len   = cbus_len_t'($urandom_range(0, 3));
            end
            if (act[m]) drv[m] = cur[m];
            else begin
               drv[m]       = rnd_req();
               drv[m].valid = 1'b0;
            end
            bus.ireqs[m] = drv[m];
         end
         rsp.data = $urandom();
         if (owner >= 0) begin
            rsp.ready = ($urandom_range(0, 3) != 0);
            rsp.last  = rsp.ready && (beat == int'(cur[owner].len));
         end else begin
            rsp.ready = 1'($urandom());
            rsp.last  = 1'($urandom());
         end
         bus.oresp = rsp;
         #1;
         exp_oreq = (owner >= 0) ? drv[owner] : '0;
         chk("rand busy", 128'(busy), 128'(owner >= 0));
         chk("rand grant_idx", 128'(grant_idx), 128'(gidx));
         chk("rand oreq", 128'(bus.oreq), 128'(exp_oreq));
         for (int m = 0; m < NM; m++) begin
            exp_rsp = (owner == m) ? rsp : '0;
            chk($sformatf("rand iresps%0d", m), 128'(bus.iresps[m]), 128'(exp_rsp));
         end
         if (owner >= 0) begin
            if (rsp.ready && rsp.last) begin
               act[owner] = 1'b0;
               prev       = owner;
               owner      = -1;
               beat       = 0;
            end else if (rsp.ready) begin
               beat++;
            end
         end else begin
            for (int k = 1; k <= NM; k++) begin
               if (owner < 0 && drv[(prev + k) % NM].valid) begin
                  owner = (prev + k) % NM;
                  gidx  = owner;
               end
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
